// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, S-box functions and the
// SubBytes engine state encoding. Reused by the other round datapath blocks.
package aes_pkg;

    localparam int AES_BLOCK_W   = 128;
    localparam int AES_BYTE_W    = 8;
    localparam int AES_NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } sbi_state_t;

    // Rotate a byte left by n positions (0 < n < 8).
    function automatic logic [7:0] rotl8(input logic [7:0] v, input int unsigned n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Forward S-box: inversion followed by the affine transform.
    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        logic [7:0] v;
        v = gf_inv(b);
        return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
    endfunction

    // Inverse S-box: inverse affine transform followed by inversion.
    function automatic logic [7:0] aes_inv_sbox(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/sbox_lane.sv
// One combinational S-box lane. The inverse table exists only when INV_EN=1.
module sbox_lane
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    // NOTE: both branches are continuous assigns that always drive out,
    // so no path leaves the output unassigned and no latch can appear.
    if (INV_EN) begin : g_fwd_inv
        assign out = inv ? aes_inv_sbox(in) : aes_sbox(in);
    end else begin : g_fwd_only
        logic unused_inv;
        assign unused_inv = inv;
        assign out        = aes_sbox(in);
    end

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes engine: LANES bytes per beat, 16/LANES beats
// per block, valid/ready on both sides, fully registered outputs.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES  = 4,
    parameter bit INV_EN = 1'b1
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [AES_BLOCK_W-1:0] i_state,
    input  logic                   i_inv,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [AES_BLOCK_W-1:0] o_state,
    output logic                   o_busy
);

    localparam int BEATS  = (LANES > 0) ? AES_NUM_BYTES / LANES : 1;
    localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LANE_W = AES_BYTE_W * LANES;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (LANES < 1 || LANES > AES_NUM_BYTES || (AES_NUM_BYTES % LANES) != 0) begin : g_bad_lanes
        $error("sub_bytes_iter: LANES must divide 16 (1, 2, 4, 8 or 16)");
    end

    sbi_state_t             state;
    logic [CNT_W-1:0]       beat;
    logic [AES_BLOCK_W-1:0] work;
    logic [AES_BLOCK_W-1:0] work_next;
    logic                   mode;
    logic [LANE_W-1:0]      lane_in;
    logic [LANE_W-1:0]      lane_out;

    // The most significant LANES bytes are substituted each beat.
    assign lane_in = work[AES_BLOCK_W-1 -: LANE_W];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane #(.INV_EN(INV_EN)) u_lane (
            .in  (lane_in [LANE_W-1-AES_BYTE_W*l -: AES_BYTE_W]),
            .inv (mode),
            .out (lane_out[LANE_W-1-AES_BYTE_W*l -: AES_BYTE_W])
        );
    end

    // Rotating the substituted bytes into the bottom restores the original
    // byte order after BEATS shifts.
    if (LANES == AES_NUM_BYTES) begin : g_single_beat
        assign work_next = lane_out;
    end else begin : g_multi_beat
        assign work_next = {work[AES_BLOCK_W-LANE_W-1:0], lane_out};
    end

    // Control FSM, beat counter, work register, mode bit and output registers.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            beat    <= '0;
            work    <= '0;
            mode    <= 1'b0;
            o_valid <= 1'b0;
            o_state <= '0;
            o_busy  <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        work    <= i_state;
                        mode    <= i_inv & INV_EN;
                        beat    <= '0;
                        state   <= BUSY;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    work <= work_next;
                    if (beat == LAST_BEAT) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_state <= work_next;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_state <= '0;
                        o_busy  <= 1'b0;
                        o_ready <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_state <= '0;
                    o_busy  <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: six engines (LANES 4/1/2/8/16 with inverse lanes,
// LANES 4 forward-only) checked every cycle against a latency/queue model
// whose S-box tables are built from the generator-3 walk of GF(2^8).
module tb_sub_bytes_iter;

    localparam int N = 6;

    function automatic int lanes_of(input int g);
        case (g)
            0: return 4;
            1: return 1;
            2: return 2;
            3: return 8;
            4: return 16;
            default: return 4;
        endcase
    endfunction

    function automatic bit inv_en_of(input int g);
        return (g == 5) ? 1'b0 : 1'b1;
    endfunction

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_inv   = '0;
    logic [N-1:0]   ds_ready = '1;
    logic [127:0]   in_state [N];
    logic [N-1:0]   rdy;
    logic [N-1:0]   vld;
    logic [N-1:0]   busy;
    logic [127:0]   out_state [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        sub_bytes_iter #(.LANES(lanes_of(g)), .INV_EN(inv_en_of(g))) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_valid (in_valid[g]),
            .o_ready (rdy[g]),
            .i_state (in_state[g]),
            .i_inv   (in_inv[g]),
            .o_valid (vld[g]),
            .i_ready (ds_ready[g]),
            .o_state (out_state[g]),
            .o_busy  (busy[g])
        );
    end

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference S-box tables built independently of the design.
    logic [7:0] tfwd [256];
    logic [7:0] tinv [256];

    function automatic logic [7:0] rol(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_tables();
        logic [7:0] p, q, t;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            t = p[7] ? 8'h1b : 8'h00;
            p = p ^ {p[6:0], 1'b0} ^ t;
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            tfwd[p] = q ^ rol(q, 1) ^ rol(q, 2) ^ rol(q, 3) ^ rol(q, 4) ^ 8'h63;
        end
        tfwd[0] = 8'h63;
        for (int i = 0; i < 256; i++) tinv[tfwd[i]] = 8'(i);
    endtask

    function automatic logic [127:0] model(input logic [127:0] s, input logic inv);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            b = s[127-8*i -: 8];
            r[127-8*i -: 8] = inv ? tinv[b] : tfwd[b];
        end
        return r;
    endfunction

    // Cycle model: an accepted block is due BEATS edges after acceptance and
    // stays until the downstream handshake.
    logic         pend [N];
    int           due  [N];
    logic [127:0] expq [N];

    initial for (int k = 0; k < N; k++) begin
        pend[k] = 1'b0;
        due[k]  = 0;
        expq[k] = '0;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            logic [131:0] act, exp;
            logic         ev;
            ev = 1'b0;
            if (rst) begin
                exp     = {1'b0, 1'b0, 1'b1, 1'b0, 128'h0};
                pend[k] = 1'b0;
            end else begin
                ev  = pend[k] && (cyc >= due[k]);
                exp = {1'b0, ev, !pend[k], pend[k], ev ? expq[k] : 128'h0};
            end
            act = {1'b0, vld[k], rdy[k], busy[k], out_state[k]};
            check($sformatf("d%0d cyc%0d {vld,rdy,busy,state}", k, cyc), act, exp);
            if (!rst) begin
                if (ev && ds_ready[k]) begin
                    pend[k] = 1'b0;
                end else if (!pend[k] && in_valid[k]) begin
                    pend[k] = 1'b1;
                    due[k]  = cyc + 1 + 16 / lanes_of(k);
                    expq[k] = model(in_state[k], in_inv[k] & inv_en_of(k));
                end
            end
        end
    end

    // Present a block and hold it until the engine takes it.
    task automatic send(input int k, input logic [127:0] s, input logic inv);
        int n;
        n = 0;
        in_valid[k] = 1'b1;
        in_state[k] = s;
        in_inv[k]   = inv;
        while (!rdy[k] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("d%0d accept timeout", k), {131'h0, rdy[k]}, 132'h1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, output logic [127:0] res);
        int n;
        n = 0;
        while (!vld[k] && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check($sformatf("d%0d result timeout", k), {131'h0, vld[k]}, 132'h1);
        res = out_state[k];
    endtask

    localparam logic [127:0] V_PLAIN = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V_SUB   = 128'h638293c31bfc33f5c4eeacea4bc12816;

    initial begin
        logic [127:0] res, held;
        for (int k = 0; k < N; k++) in_state[k] = '0;
        build_tables();

        // Pin the reference tables to known values.
        check("pin sbox[00]", {124'h0, tfwd[8'h00]}, {124'h0, 8'h63});
        check("pin sbox[53]", {124'h0, tfwd[8'h53]}, {124'h0, 8'hed});
        check("pin invsbox[16]", {124'h0, tinv[8'h16]}, {124'h0, 8'hff});
        check("pin model fwd", {4'h0, model(V_PLAIN, 1'b0)}, {4'h0, V_SUB});

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset outputs d0", {1'b0, vld[0], rdy[0], busy[0], out_state[0]},
              {1'b0, 1'b0, 1'b1, 1'b0, 128'h0});

        // Forward vector, then its inverse.
        send(0, V_PLAIN, 1'b0);
        wait_done(0, res);
        check("t1 SubBytes", {4'h0, res}, {4'h0, V_SUB});
        send(0, V_SUB, 1'b1);
        wait_done(0, res);
        check("t2 InvSubBytes", {4'h0, res}, {4'h0, V_PLAIN});

        // Same block through every lane count.
        for (int k = 0; k < 5; k++) begin
            send(k, {16{8'h53}}, 1'b0);
            wait_done(k, res);
            check($sformatf("t3 all53 lanes%0d", lanes_of(k)), {4'h0, res}, {4'h0, {16{8'hed}}});
        end

        // Downstream stall with ignored valid pulses.
        ds_ready[0] = 1'b0;
        send(0, V_PLAIN, 1'b0);
        wait_done(0, held);
        for (int i = 0; i < 10; i++) begin
            in_valid[0] = ~in_valid[0];
            in_state[0] = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
            check($sformatf("t4 stall %0d", i), {1'b0, vld[0], rdy[0], 1'b0, out_state[0]},
                  {1'b0, 1'b1, 1'b0, 1'b0, V_SUB});
        end
        in_valid[0] = 1'b0;
        ds_ready[0] = 1'b1;
        @(posedge clk); #1;
        check("t4 release to idle", {130'h0, vld[0], rdy[0]}, {130'h0, 1'b0, 1'b1});

        // Reset in the middle of a block.
        send(0, V_PLAIN, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("t5 abort outputs", {1'b0, vld[0], rdy[0], busy[0], out_state[0]},
              {1'b0, 1'b0, 1'b1, 1'b0, 128'h0});
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, {16{8'h53}}, 1'b1);
        wait_done(0, res);
        check("t5 block after abort", {4'h0, res}, {4'h0, {16{8'h50}}});

        // Forward-only engine ignores the inverse request.
        send(5, 128'h0, 1'b1);
        wait_done(5, res);
        check("t6 fwd only", {4'h0, res}, {4'h0, {16{8'h63}}});

        // Back-to-back random blocks; the per-cycle model checks each result.
        for (int i = 0; i < 1000; i++)
            send(5, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 200; i++)
            send(0, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
        wait_done(0, res);
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
